// File: rtl/moving_average_win.sv
// moving_average_win: streaming moving-average filter over signed samples.
//
// Keeps the last DEPTH = 2**LOG2_DEPTH accepted samples in a circular buffer and
// updates a running sum incrementally (add newest, subtract evicted). The average
// is the running sum shifted right by LOG2_DEPTH.
//
// Build option: define MOVING_AVERAGE_ROUND_EN to round the average half-up
// (toward +inf). Otherwise the average is floored (plain arithmetic shift).
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset, highest priority
//   clear      synchronous flush of window, sum and fill count; drops a same-cycle sample
//   in_valid   in_data carries a new sample this cycle
//   in_data    signed sample
//   out_valid  one-cycle pulse after an accept that leaves the window full
//   out_data   signed window average, held between out_valid pulses
//   out_sum    signed running sum of the window (tracks every accept)
//   out_fill   samples currently in the window, saturates at DEPTH
module moving_average_win #(
  parameter int DATA_W     = 8,
  parameter int LOG2_DEPTH = 4,
  localparam int SUM_W     = DATA_W + LOG2_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic signed [SUM_W-1:0]  out_sum,
  output logic [LOG2_DEPTH:0]      out_fill
);

  localparam int Depth = 2 ** LOG2_DEPTH;
  localparam int PtrW  = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
  localparam int FillW = LOG2_DEPTH + 1;
`ifdef MOVING_AVERAGE_ROUND_EN
  // Half an output LSB; zero when the window is a single sample.
  localparam int HalfLsb = (2 ** LOG2_DEPTH) / 2;
`endif

  logic signed [DATA_W-1:0] buf_q [Depth];
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic [PtrW-1:0]          wptr_q, wptr_d;
  logic [FillW-1:0]         fill_q, fill_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;

  logic                     accept;
  logic signed [DATA_W-1:0] evicted;
  logic signed [DATA_W-1:0] avg;
`ifdef MOVING_AVERAGE_ROUND_EN
  logic signed [SUM_W:0]    rnd;
`endif

  assign accept  = in_valid & ~clear;
  assign evicted = buf_q[wptr_q];

  always_comb begin
    sum_d       = sum_q;
    wptr_d      = wptr_q;
    fill_d      = fill_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    avg         = '0;
`ifdef MOVING_AVERAGE_ROUND_EN
    rnd         = '0;
`endif

    if (clear) begin
      sum_d      = '0;
      wptr_d     = '0;
      fill_d     = '0;
      out_data_d = '0;
    end else if (accept) begin
      // Entries not yet written are zero, so warm-up partial sums stay exact.
      sum_d  = sum_q + SUM_W'(in_data) - SUM_W'(evicted);
      wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
      fill_d = (fill_q == FillW'(Depth)) ? fill_q : fill_q + FillW'(1);

`ifdef MOVING_AVERAGE_ROUND_EN
      // One extra bit so adding the half LSB cannot wrap at the positive limit.
      rnd = (SUM_W + 1)'(sum_d) + (SUM_W + 1)'(HalfLsb);
      avg = DATA_W'(rnd >>> LOG2_DEPTH);
`else
      avg = DATA_W'(sum_d >>> LOG2_DEPTH);
`endif

      if (fill_d == FillW'(Depth)) begin
        out_valid_d = 1'b1;
        out_data_d  = avg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      wptr_q      <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      sum_q       <= sum_d;
      wptr_q      <= wptr_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < Depth; i++) begin
        buf_q[i] <= '0;
      end
    end else if (accept) begin
      buf_q[wptr_q] <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sum   = sum_q;
  assign out_fill  = fill_q;

endmodule
